// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and default widths used by the load/store path.
package cpu_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mau_state_t;
   localparam int WORD_W = 16;
   localparam int DMEM_DEPTH = 256;
endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit driving a fixed-latency synchronous data memory.
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W = WORD_W,
   parameter int ADDR_W = 16,
   parameter int DEPTH = DMEM_DEPTH,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] ReadData,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);
   // one extra bit so DEPTH == 2**ADDR_W never flags an address
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
   localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY-1);
   mau_state_t state;
   logic wr;
   logic [1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err <= 1'b0;
         ReadData <= '0;
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         wr <= 1'b0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  wr <= req_write;
                  if ({1'b0, req_addr} >= LIMIT) begin
                     rsp_err <= 1'b1;
                     rsp_valid <= 1'b1;
                     ReadData <= '0;
                     state <= RESP;
                  end else begin
                     mem_addr <= req_addr;
                     mem_wdata <= req_wdata;
                     mem_we <= req_write;
                     mem_re <= !req_write;
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mem_we <= 1'b0;
               mem_re <= 1'b0;
               cnt <= CNT_INIT;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == 2'd0) begin
                  ReadData <= wr ? '0 : mem_rdata;
                  rsp_valid <= 1'b1;
                  state <= RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err <= 1'b0;
                  req_ready <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: two units (latency 1 and 4) against behavioural memories and a reference model.
module tb_mem_access_unit;
   localparam int L0 = 1;
   localparam int L1 = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] rv, rw, rr, ready, vld, err, we, re;
   logic [15:0] ra [2];
   logic [15:0] rwd [2];
   logic [15:0] rdata [2];
   logic [15:0] maddr [2];
   logic [15:0] mwdata [2];
   logic [15:0] mrdata [2];

   logic [15:0] mem [2][256] = '{default: '{default: 16'h0}};
   logic [15:0] ref_mem [2][256] = '{default: '{default: 16'h0}};
   logic [15:0] pipe [2][4] = '{default: '{default: 16'hDEAD}};
   logic [15:0] strobe_addr [2] = '{default: 16'h0};
   logic [15:0] strobe_wdata [2] = '{default: 16'h0};
   int we_cnt [2] = '{0, 0};
   int re_cnt [2] = '{0, 0};
   int cyc = 0;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_LATENCY(L0)) u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(ready[0]), .req_write(rw[0]),
      .req_addr(ra[0]), .req_wdata(rwd[0]), .rsp_valid(vld[0]), .rsp_ready(rr[0]),
      .ReadData(rdata[0]), .rsp_err(err[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
      .mem_we(we[0]), .mem_re(re[0]), .mem_rdata(mrdata[0]));

   mem_access_unit #(.MEM_LATENCY(L1)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(ready[1]), .req_write(rw[1]),
      .req_addr(ra[1]), .req_wdata(rwd[1]), .rsp_valid(vld[1]), .rsp_ready(rr[1]),
      .ReadData(rdata[1]), .rsp_err(err[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
      .mem_we(we[1]), .mem_re(re[1]), .mem_rdata(mrdata[1]));

   // synchronous memory: read data appears MEM_LATENCY edges after the strobe, junk otherwise
   assign mrdata[0] = pipe[0][L0-1];
   assign mrdata[1] = pipe[1][L1-1];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int u = 0; u < 2; u++) begin
         if (we[u]) begin
            mem[u][maddr[u][7:0]] <= mwdata[u];
            we_cnt[u] <= we_cnt[u] + 1;
            strobe_addr[u] <= maddr[u];
            strobe_wdata[u] <= mwdata[u];
         end
         if (re[u]) begin
            re_cnt[u] <= re_cnt[u] + 1;
            strobe_addr[u] <= maddr[u];
         end
         for (int i = 3; i > 0; i--) pipe[u][i] <= pipe[u][i-1];
         pipe[u][0] <= re[u] ? mem[u][maddr[u][7:0]] : 16'hDEAD;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic void model(input int u, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                                 output logic [15:0] d, output bit e, output int lat);
      e = a >= 16'd256;
      lat = e ? 1 : (u == 0 ? L0 : L1) + 2;
      d = (wr || e) ? 16'h0 : ref_mem[u][a[7:0]];
      if (wr && !e) ref_mem[u][a[7:0]] = wd;
   endfunction

   task automatic chk_reset(input int u, input string nm);
      chk(nm, {ready[u], vld[u], err[u], rdata[u], we[u], re[u]}, 32'h0);
      chk({nm, "_mem"}, {maddr[u], mwdata[u]}, 32'h0);
   endtask

   task automatic expect_req(input string nm, input int u, input bit wr, input logic [15:0] a,
                             input logic [15:0] wd, input int stall, input logic [15:0] xd,
                             input bit xe, input int xlat);
      int w0, r0, k, lat;
      logic [15:0] d;
      bit e;
      k = 0;
      @(negedge clk);
      while (!ready[u] && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!ready[u]) begin
         chk({nm, "_ready"}, 32'(ready[u]), 32'h1);
         return;
      end
      w0 = we_cnt[u];
      r0 = re_cnt[u];
      rv[u] = 1'b1; rw[u] = wr; ra[u] = a; rwd[u] = wd; rr[u] = (stall == 0);
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         rv[u] = 1'b0;
         if (vld[u]) lat = c;
      end
      chk({nm, "_lat"}, 32'(lat), 32'(xlat));
      if (lat == 0) begin
         rr[u] = 1'b0;
         return;
      end
      d = rdata[u];
      e = err[u];
      chk({nm, "_data"}, 32'(d), 32'(xd));
      chk({nm, "_err"}, 32'(e), 32'(xe));
      for (int s = 0; s < stall; s++) begin
         rv[u] = 1'b1;
         ra[u] = 16'h0003;
         @(negedge clk);
         chk({nm, "_stall"}, {vld[u], ready[u], rdata[u], err[u]}, {1'b1, 1'b0, d, e});
      end
      rv[u] = 1'b0;
      rr[u] = 1'b1;
      @(negedge clk);
      rr[u] = 1'b0;
      chk({nm, "_done"}, {vld[u], ready[u]}, 2'b01);
      chk({nm, "_we"}, 32'(we_cnt[u] - w0), 32'(wr && !xe));
      chk({nm, "_re"}, 32'(re_cnt[u] - r0), 32'(!wr && !xe));
      if (!xe) chk({nm, "_maddr"}, 32'(strobe_addr[u]), 32'(a));
      if (wr && !xe) chk({nm, "_mwdata"}, 32'(strobe_wdata[u]), 32'(wd));
   endtask

   typedef struct {
      int u; bit wr; logic [15:0] a; logic [15:0] wd; int stall;
      logic [15:0] xd; bit xe; int xlat;
   } vec_t;

   initial begin
      vec_t tv [10];
      logic [15:0] d, xq[$], gq[$];
      logic [15:0] addrs [3];
      bit e;
      int l, n, seen, k;
      int acc [3];
      tv[0] = '{0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 0, 3};
      tv[1] = '{0, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0, 3};
      tv[2] = '{0, 0, 16'h0100, 16'h0000, 0, 16'h0000, 1, 1};
      tv[3] = '{1, 1, 16'h0040, 16'hCAFE, 0, 16'h0000, 0, 6};
      tv[4] = '{1, 0, 16'h0040, 16'h0000, 0, 16'hCAFE, 0, 6};
      tv[5] = '{1, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, 1, 1};
      tv[6] = '{0, 0, 16'h00FF, 16'h0000, 0, 16'h0000, 0, 3};
      tv[7] = '{0, 1, 16'h00FF, 16'h1357, 0, 16'h0000, 0, 3};
      tv[8] = '{0, 1, 16'h0020, 16'h1234, 0, 16'h0000, 0, 3};
      tv[9] = '{0, 0, 16'h0020, 16'h0000, 5, 16'h1234, 0, 3};

      rst_n = 1'b0;
      rv = '0; rw = '0; rr = '0;
      ra = '{default: 16'h0}; rwd = '{default: 16'h0};
      repeat (3) @(negedge clk);
      chk_reset(0, "reset_u0");
      chk_reset(1, "reset_u1");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(ready), 32'h3);

      for (int i = 0; i < 10; i++) begin
         model(tv[i].u, tv[i].wr, tv[i].a, tv[i].wd, d, e, l);
         expect_req($sformatf("vec%0d", i), tv[i].u, tv[i].wr, tv[i].a, tv[i].wd, tv[i].stall,
                    tv[i].xd, tv[i].xe, tv[i].xlat);
      end

      // back-to-back loads on the latency-1 unit with rsp_ready held high
      addrs = '{16'h0010, 16'h0020, 16'h00FF};
      acc = '{0, 0, 0};
      for (int i = 0; i < 3; i++) begin
         model(0, 1'b0, addrs[i], 16'h0, d, e, l);
         xq.push_back(d);
      end
      rr[0] = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && gq.size() < 3; c++) begin
         @(negedge clk);
         if (vld[0]) gq.push_back(rdata[0]);
         if (ready[0]) begin
            if (n < 3) begin
               rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = addrs[n];
               acc[n] = cyc;
               n++;
            end else rv[0] = 1'b0;
         end
      end
      rv[0] = 1'b0;
      rr[0] = 1'b0;
      chk("b2b_count", 32'(gq.size()), 32'd3);
      chk("b2b_gap0", 32'(acc[1] - acc[0]), 32'(L0 + 3));
      chk("b2b_gap1", 32'(acc[2] - acc[1]), 32'(L0 + 3));
      for (int i = 0; i < 3 && i < gq.size(); i++) chk($sformatf("b2b_data%0d", i), 32'(gq[i]), 32'(xq[i]));

      // reset asserted while the latency-4 unit waits on memory
      k = 0;
      @(negedge clk);
      while (!ready[1] && k < 50) begin
         @(negedge clk);
         k++;
      end
      rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 16'h0040; rr[1] = 1'b1;
      @(negedge clk);
      rv[1] = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset(1, "rst_mid");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         seen += int'(vld[1]);
      end
      rr[1] = 1'b0;
      chk("rst_no_rsp", 32'(seen), 32'h0);
      chk("rst_ready", 32'(ready[1]), 32'h1);
      model(1, 1'b0, 16'h0040, 16'h0, d, e, l);
      expect_req("after_rst", 1, 1'b0, 16'h0040, 16'h0, 0, d, e, l);

      for (int i = 0; i < 60; i++) begin
         int u, st;
         bit wr;
         logic [15:0] a, wd;
         u = $urandom_range(0, 1);
         wr = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? 16'(256 + $urandom_range(0, 65279)) : 16'($urandom_range(240, 255));
         wd = 16'($urandom);
         st = $urandom_range(0, 2);
         model(u, wr, a, wd, d, e, l);
         expect_req($sformatf("rnd%0d", i), u, wr, a, wd, st, d, e, l);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
